// File: rtl/secret_code_gen.sv
// secret_code_gen: builds a NUM_DIGITS-digit code from a free-running PRBS word.
// Each COLLECT cycle samples prbs_in[3:0] as a candidate digit. A candidate
// larger than DIGIT_MAX is rejected. An accepted candidate fills the next slot,
// starting at digit 0. If MAX_TRIES candidates are evaluated without filling
// the last slot, the block finishes with an error.
//
// Build option:
//   UNIQUE_DIGITS_EN - also reject candidates that are already present in the
//                      current code, so all digits are distinct
//                      (requires NUM_DIGITS <= DIGIT_MAX+1).
//
// Ports:
//   clk        - clock, rising edge
//   resetb     - asynchronous active-low reset
//   prbs_in    - pseudo-random word, new value each cycle (low nibble used)
//   gen_req    - request a new code (ignored while busy)
//   busy       - high while collecting digits
//   code_valid - high while a finished code is presented
//   code_err   - high with code_valid when the try budget ran out
//   code_out   - packed digits, digit k in bits [4k+3:4k]
module secret_code_gen #(
  parameter int unsigned PRBS_W     = 16,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIGIT_MAX  = 9,
  parameter int unsigned MAX_TRIES  = 64
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic [PRBS_W-1:0]       prbs_in,
  input  logic                    gen_req,
  output logic                    busy,
  output logic                    code_valid,
  output logic                    code_err,
  output logic [4*NUM_DIGITS-1:0] code_out
);

  localparam int unsigned CODE_W = 4 * NUM_DIGITS;
  localparam int unsigned SLOT_W = $clog2(NUM_DIGITS + 1);
  localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
  localparam logic [3:0]        DIGIT_LIM = 4'(DIGIT_MAX);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_DIGITS - 1);
  localparam logic [TRY_W-1:0]  TRY_LIM   = TRY_W'(MAX_TRIES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [TRY_W-1:0]    tries_q, tries_d;
  logic [CODE_W-1:0]   code_d;
  logic                err_d;

  // Candidate nibble is registered, then judged one cycle later. cand_vld_q
  // marks a nibble that was sampled while in COLLECT.
  logic [3:0]          cand_q;
  logic                cand_vld_q;

  logic                in_range_c;
  logic                dup_c;
  logic                accept_c;
  logic                last_c;
  logic                prbs_unused;

  // Only the low nibble of the PRBS word carries a candidate.
  assign prbs_unused = ^prbs_in;

  assign in_range_c = (cand_q <= DIGIT_LIM);
  assign last_c     = (slot_q == LAST_SLOT);

`ifdef UNIQUE_DIGITS_EN
  // Duplicate check covers only the slots already written in this code.
  always_comb begin
    dup_c = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if ((SLOT_W'(k) < slot_q) && (code_out[4*k +: 4] == cand_q)) begin
        dup_c = 1'b1;
      end
    end
  end
`else
  assign dup_c = 1'b0;
`endif

  assign accept_c = in_range_c && !dup_c;

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    tries_d = tries_q;
    code_d  = code_out;
    err_d   = code_err;

    case (state_q)
      IDLE, DONE: begin
        if (gen_req) begin
          state_d = COLLECT;
          slot_d  = '0;
          tries_d = '0;
          code_d  = '0;
          err_d   = 1'b0;
        end
      end

      COLLECT: begin
        if (cand_vld_q) begin
          tries_d = tries_q + TRY_W'(1);
          if (accept_c) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
              if (slot_q == SLOT_W'(k)) begin
                code_d[4*k +: 4] = cand_q;
              end
            end
            slot_d = slot_q + SLOT_W'(1);
          end
          // Completing the code takes priority over an expiring budget.
          if (accept_c && last_c) begin
            state_d = DONE;
            err_d   = 1'b0;
          end else if (tries_d == TRY_LIM) begin
            state_d = DONE;
            err_d   = 1'b1;
            code_d  = '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      tries_q    <= '0;
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
      busy       <= 1'b0;
      code_valid <= 1'b0;
      code_err   <= 1'b0;
      code_out   <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      tries_q    <= tries_d;
      cand_q     <= prbs_in[3:0];
      cand_vld_q <= (state_q == COLLECT);
      busy       <= (state_d == COLLECT);
      code_valid <= (state_d == DONE);
      code_err   <= err_d;
      code_out   <= code_d;
    end
  end

endmodule
